// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - Default program address width.
//   - FSM state encodings, which are also driven straight onto the `state` output.
//   - Select codes for the next-pc multiplexer.
package pc_seq_pkg;

  localparam int unsigned DefaultAddrW = 5;

  typedef logic [1:0] state_t;

  // The encodings are visible on the `state` output, so they must not be reordered.
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StHalt  = 2'd2;
  localparam state_t StFault = 2'd3;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t SelHold   = 2'd0;
  localparam pc_sel_t SelInc    = 2'd1;
  localparam pc_sel_t SelStack  = 2'd2;
  localparam pc_sel_t SelTarget = 2'd3;

endpackage

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses used for call/return.
// Ports:
//   clk    - clock; all state changes on the rising edge
//   nReset - synchronous, active-high reset; empties the stack
//   push   - write din on top (ignored when full)
//   pop    - discard the top entry (ignored when empty)
//   din    - address to push
//   dout   - current top entry (0 when empty)
//   full   - STACK_DEPTH entries held
//   empty  - no entries held
module return_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

  assign full  = (32'(cnt_q) == STACK_DEPTH);
  assign empty = (cnt_q == '0);

  // The top entry sits at index cnt_q-1. It is selected with a loop, so no
  // narrow subtraction is needed when the stack is empty.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (32'(cnt_q) == i + 1) begin
        dout = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !full) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (32'(cnt_q) == i) begin
          mem_q[i] <= din;
        end
      end
      cnt_q <= cnt_q + CntW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller for the instruction address.
// Ports:
//   clk, nReset   - clock and synchronous, active-high reset
//   start         - leave IDLE or HALT and enter RUN
//   stall         - freeze pc, stack and state for this cycle (RUN only)
//   halt          - advance pc once, then stop fetching
//   jump_en       - unconditional jump to target
//   branch_en     - branch to target when branch_cond is set
//   branch_cond   - branch-taken condition
//   call_en       - push pc+1 and jump to target
//   ret_en        - pop the return address into pc
//   target        - jump, branch or call destination
//   pc            - registered fetch address
//   pc_valid      - registered fetch qualifier
//   state         - IDLE=0, RUN=1, HALT=2, FAULT=3
//   stack_ovf     - sticky: call attempted with a full stack
//   stack_unf     - sticky: return attempted with an empty stack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned           ADDR_W      = DefaultAddrW,
  parameter int unsigned           STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]     RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              jump_en,
  input  logic              branch_en,
  input  logic              branch_cond,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [1:0]        state,
  output logic              stack_ovf,
  output logic              stack_unf
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  pc_sel_t           pc_sel;

  logic              stk_push, stk_pop;
  logic [ADDR_W-1:0] stk_dout;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] pc_inc;

  // Arithmetic wraps modulo 2^ADDR_W, so a return address past the top becomes 0.
  assign pc_inc = pc_q + ADDR_W'(1);

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk    (clk),
    .nReset (nReset),
    .push   (stk_push),
    .pop    (stk_pop),
    .din    (pc_inc),
    .dout   (stk_dout),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  // Next-state and strobe decode. The if/else chain encodes the RUN priority order.
  always_comb begin
    state_d  = state_q;
    pc_sel   = SelHold;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stall) begin
          pc_sel = SelHold;
        end else if (halt) begin
          pc_sel  = SelInc;
          state_d = StHalt;
        end else if (ret_en) begin
          if (!stk_empty) begin
            stk_pop = 1'b1;
            pc_sel  = SelStack;
          end else begin
            unf_d   = 1'b1;
            state_d = StFault;
          end
        end else if (call_en) begin
          if (!stk_full) begin
            stk_push = 1'b1;
            pc_sel   = SelTarget;
          end else begin
            ovf_d   = 1'b1;
            state_d = StFault;
          end
        end else if (jump_en) begin
          pc_sel = SelTarget;
        end else if (branch_en && branch_cond) begin
          pc_sel = SelTarget;
        end else begin
          pc_sel = SelInc;
        end
      end
      StHalt: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StFault;
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      SelHold:   pc_d = pc_q;
      SelInc:    pc_d = pc_inc;
      SelStack:  pc_d = stk_dout;
      SelTarget: pc_d = target;
      default:   pc_d = pc_q;
    endcase
  end

  // The qualifier is registered alongside pc, so it follows stall by one edge.
  assign pc_valid_d = (state_d == StRun) && !stall;

  always_ff @(posedge clk) begin
    if (nReset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_ADDR;
      pc_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign state     = state_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, self-checking bench for pc_sequencer. Each step drives strobes,
// queues the expected {pc, pc_valid, state, stack_ovf, stack_unf}, and after
// the clock edge pops the expectation and compares it with the outputs.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       nReset;
  logic       start, stall, halt, jump_en, branch_en, branch_cond, call_en, ret_en;
  logic [4:0] target;
  logic [4:0] pc;
  logic       pc_valid;
  logic [1:0] state;
  logic       stack_ovf, stack_unf;

  int tests = 0;
  int fails = 0;

  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W      (5),
    .STACK_DEPTH (4),
    .RESET_ADDR  (5'd0)
  ) dut (
    .clk         (clk),
    .nReset      (nReset),
    .start       (start),
    .stall       (stall),
    .halt        (halt),
    .jump_en     (jump_en),
    .branch_en   (branch_en),
    .branch_cond (branch_cond),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .target      (target),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .state       (state),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  task automatic clear_strobes();
    start       = 1'b0;
    stall       = 1'b0;
    halt        = 1'b0;
    jump_en     = 1'b0;
    branch_en   = 1'b0;
    branch_cond = 1'b0;
    call_en     = 1'b0;
    ret_en      = 1'b0;
    target      = 5'd0;
  endtask

  // One clock step: strobes already driven by the caller are sampled at the next edge.
  task automatic cyc(input string tag, input int e_pc, input bit e_v, input int e_st,
                     input bit e_o, input bit e_u);
    logic [9:0] exp_w;
    logic [9:0] obs_w;
    sb_q.push_back({5'(e_pc), e_v, 2'(e_st), e_o, e_u});
    @(posedge clk);
    #1;
    exp_w = sb_q.pop_front();
    obs_w = {pc, pc_valid, state, stack_ovf, stack_unf};
    tests++;
    assert (obs_w === exp_w) else begin
      fails++;
      $error("FAIL %s: pc/valid/state/ovf/unf observed %0d/%b/%0d/%b/%b expected %0d/%b/%0d/%b/%b",
             tag, obs_w[9:5], obs_w[4], obs_w[3:2], obs_w[1], obs_w[0],
             exp_w[9:5], exp_w[4], exp_w[3:2], exp_w[1], exp_w[0]);
    end
    clear_strobes();
  endtask

  initial begin
    clear_strobes();
    nReset = 1'b1;
    // Reset, with a strobe present that reset must override.
    start = 1'b1;
    cyc("reset", 0, 0, 0, 0, 0);
    cyc("reset2", 0, 0, 0, 0, 0);
    nReset = 1'b0;
    jump_en = 1'b1; target = 5'd12;
    cyc("idle_ignores", 0, 0, 0, 0, 0);

    // Start and free run with wrap.
    start = 1'b1;
    cyc("start", 0, 1, 1, 0, 0);
    for (int i = 1; i < 32; i++) cyc("inc", i, 1, 1, 0, 0);
    cyc("wrap", 0, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc("inc2", i, 1, 1, 0, 0);

    // Jump and branch.
    jump_en = 1'b1; target = 5'd20;
    cyc("jump", 20, 1, 1, 0, 0);
    cyc("inc3", 21, 1, 1, 0, 0);
    branch_en = 1'b1; branch_cond = 1'b0; target = 5'd9;
    cyc("br_not_taken", 22, 1, 1, 0, 0);
    branch_en = 1'b1; branch_cond = 1'b1; target = 5'd9;
    cyc("br_taken", 9, 1, 1, 0, 0);
    jump_en = 1'b1; branch_en = 1'b1; branch_cond = 1'b0; target = 5'd17;
    cyc("jump_over_branch", 17, 1, 1, 0, 0);

    // Nested call/return from pc=3.
    jump_en = 1'b1; target = 5'd3;
    cyc("to3", 3, 1, 1, 0, 0);
    call_en = 1'b1; target = 5'd10;
    cyc("call1", 10, 1, 1, 0, 0);
    call_en = 1'b1; target = 5'd25;
    cyc("call2", 25, 1, 1, 0, 0);
    ret_en = 1'b1;
    cyc("ret1", 11, 1, 1, 0, 0);
    ret_en = 1'b1; call_en = 1'b1; target = 5'd2;
    cyc("ret2_over_call", 4, 1, 1, 0, 0);

    // Stall and halt.
    jump_en = 1'b1; target = 5'd7;
    cyc("to7", 7, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      cyc("stall", 7, 0, 1, 0, 0);
    end
    cyc("after_stall", 8, 1, 1, 0, 0);
    halt = 1'b1; jump_en = 1'b1; target = 5'd1;
    cyc("halt", 9, 0, 2, 0, 0);
    jump_en = 1'b1; target = 5'd1;
    cyc("halt_ignores", 9, 0, 2, 0, 0);
    start = 1'b1;
    cyc("resume", 9, 1, 1, 0, 0);
    cyc("inc4", 10, 1, 1, 0, 0);
    stall = 1'b1; jump_en = 1'b1; target = 5'd0;
    cyc("stall_over_jump", 10, 0, 1, 0, 0);
    cyc("inc5", 11, 1, 1, 0, 0);

    // Overflow: four calls fill the stack, the fifth faults.
    for (int i = 0; i < 4; i++) begin
      call_en = 1'b1; target = 5'(i);
      cyc("call_fill", i, 1, 1, 0, 0);
    end
    call_en = 1'b1; target = 5'd20;
    cyc("ovf", 3, 0, 3, 1, 0);
    start = 1'b1;
    cyc("fault_start", 3, 0, 3, 1, 0);
    ret_en = 1'b1;
    cyc("fault_ret", 3, 0, 3, 1, 0);
    nReset = 1'b1;
    cyc("fault_reset", 0, 0, 0, 0, 0);
    nReset = 1'b0;

    // Reset in RUN with two entries pushed, then return on empty stack.
    start = 1'b1;
    cyc("start2", 0, 1, 1, 0, 0);
    call_en = 1'b1; target = 5'd5;
    cyc("callA", 5, 1, 1, 0, 0);
    call_en = 1'b1; target = 5'd8;
    cyc("callB", 8, 1, 1, 0, 0);
    nReset = 1'b1; call_en = 1'b1; target = 5'd14;
    cyc("run_reset", 0, 0, 0, 0, 0);
    nReset = 1'b0;
    start = 1'b1;
    cyc("start3", 0, 1, 1, 0, 0);

    // Return address 31+1 is stored as 0.
    jump_en = 1'b1; target = 5'd31;
    cyc("to31", 31, 1, 1, 0, 0);
    call_en = 1'b1; target = 5'd6;
    cyc("call_wrap", 6, 1, 1, 0, 0);
    ret_en = 1'b1;
    cyc("ret_wrap", 0, 1, 1, 0, 0);
    ret_en = 1'b1;
    cyc("unf", 0, 0, 3, 0, 1);
    cyc("unf_sticky", 0, 0, 3, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
